ysyx_23060332_exu_mc: RTL and testbench

Multi-cycle, parametrised execute unit that replaces the single-cycle combinational execute stage. It sits between decode and writeback.
- Accepts one decoded instruction per valid/ready handshake.
- Performs ALU, jump-target and load/store work.
- Talks to data memory through a request/response handshake, so memory latency is unbounded.
- Presents one registered retire record per instruction, held until writeback accepts it.

---
 rtl/ysyx_23060332_exu_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_ysyx_23060332_exu_mc.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_exu_mc.sv
// ysyx_23060332_exu_mc: multi-cycle execute unit.
// ALU, jump target and load/store via req/resp memory; one held retire record.

module ysyx_23060332_exu_mc #(
    parameter int  XLEN    = 32,
    parameter int  RADDR_W = 5,
    localparam int STRB_W  = XLEN / 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        inst,
    input  logic [XLEN-1:0]    op1,
    input  logic [XLEN-1:0]    op2,
    input  logic [XLEN-1:0]    op1_jump,
    input  logic [XLEN-1:0]    op2_jump,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [RADDR_W-1:0] rd,
    input  logic               rd_wen,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_wen,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [STRB_W-1:0]  mem_wmask,
    input  logic               mem_resp_valid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_wen,
    output logic [XLEN-1:0]    wb_data,
    output logic               jump_en,
    output logic [XLEN-1:0]    jump_addr
);

    localparam int OFF_W = $clog2(STRB_W);

    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_REG   = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        MREQ,
        MWAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       accept;

    assign opc    = inst[6:0];
    assign f3     = inst[14:12];
    assign accept = in_valid && (state == IDLE);

    // Only opcode, funct3 and bit 30 carry meaning here.
    logic unused_inst;
    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

    logic            alu_ok;
    logic [XLEN-1:0] alu_res;
    logic            is_jmp;
    logic            is_ld;
    logic            is_st;

    // Decode the offered instruction and compute the ALU result.
    always_comb begin
        alu_ok  = 1'b0;
        alu_res = '0;
        is_jmp  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        unique case (opc)
            OPC_IMM, OPC_REG: begin
                alu_ok = 1'b1;
                unique case (f3)
                    3'b000: begin
                        if (opc == OPC_REG && inst[30])
                            alu_res = op1 - op2;
                        else
                            alu_res = op1 + op2;
                    end
                    3'b010: alu_res = XLEN'($signed(op1) < $signed(op2));
                    3'b011: alu_res = XLEN'(op1 < op2);
                    3'b100: alu_res = op1 ^ op2;
                    3'b110: alu_res = op1 | op2;
                    3'b111: alu_res = op1 & op2;
                    default: alu_ok = 1'b0;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                alu_ok  = 1'b1;
                alu_res = op1 + op2;
            end
            OPC_JAL, OPC_JALR: begin
                alu_ok  = 1'b1;
                is_jmp  = 1'b1;
                alu_res = op1 + op2;
            end
            OPC_LOAD: begin
                unique case (f3)
                    3'b000, 3'b001, 3'b010,
                    3'b100, 3'b101: is_ld = 1'b1;
                    3'b011, 3'b110: is_ld = (XLEN == 64);
                    default:        is_ld = 1'b0;
                endcase
            end
            OPC_STORE: begin
                unique case (f3)
                    3'b000, 3'b001, 3'b010: is_st = 1'b1;
                    3'b011:  is_st = (XLEN == 64);
                    default: is_st = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0]   jsum;
    logic [XLEN-1:0]   jaddr_c;
    logic [XLEN-1:0]   addr_c;
    logic [OFF_W-1:0]  off_c;
    logic [7:0]        bm;
    logic [STRB_W-1:0] wmask_c;
    logic [XLEN-1:0]   wdata_c;

    assign jsum    = op1_jump + op2_jump;
    assign addr_c  = op1 + op2;
    assign off_c   = addr_c[OFF_W-1:0];

    // Redirect target; JALR drops bit 0.
    always_comb begin
        jaddr_c = jsum;
        if (opc == OPC_JALR)
            jaddr_c = {jsum[XLEN-1:1], 1'b0};
    end

    // Size strobe and lane shift; bytes past the word top are dropped.
    always_comb begin
        bm = 8'h00;
        unique case (f3[1:0])
            2'b00:   bm = 8'h01;
            2'b01:   bm = 8'h03;
            2'b10:   bm = 8'h0F;
            default: bm = 8'hFF;
        endcase
        wmask_c = STRB_W'(bm) << off_c;
        wdata_c = rs2_data << {off_c, 3'b000};
    end

    logic [2:0]       f3_q;
    logic [OFF_W-1:0] off_q;
    logic             jump_en_q;
    logic [XLEN-1:0]  ld_sh;
    logic [XLEN-1:0]  ld_res;

    // Align the response word and extend to XLEN.
    always_comb begin
        ld_sh  = mem_rdata >> {off_q, 3'b000};
        ld_res = ld_sh;
        unique case (f3_q)
            3'b000:  ld_res = XLEN'($signed(ld_sh[7:0]));
            3'b001:  ld_res = XLEN'($signed(ld_sh[15:0]));
            3'b010:  ld_res = XLEN'($signed(ld_sh[31:0]));
            3'b100:  ld_res = XLEN'(ld_sh[7:0]);
            3'b101:  ld_res = XLEN'(ld_sh[15:0]);
            3'b110:  ld_res = XLEN'(ld_sh[31:0]);
            default: ld_res = ld_sh;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        wb_valid      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (is_ld || is_st) ? MREQ : DONE;
            end
            MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_nxt = MWAIT;
            end
            MWAIT: begin
                if (mem_resp_valid)
                    state_nxt = DONE;
            end
            DONE: begin
                wb_valid = 1'b1;
                if (wb_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the instruction on accept; fill load data on response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_wen <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            wb_rd       <= '0;
            wb_wen      <= 1'b0;
            wb_data     <= '0;
            jump_en_q   <= 1'b0;
            jump_addr   <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else if (accept) begin
            mem_req_wen <= is_st;
            mem_addr    <= (is_ld || is_st) ? addr_c : '0;
            mem_wdata   <= is_st ? wdata_c : '0;
            mem_wmask   <= is_st ? wmask_c : '0;
            wb_rd       <= rd;
            wb_wen      <= (alu_ok || is_ld) && rd_wen
                           && (rd != '0);
            wb_data     <= alu_ok ? alu_res : '0;
            jump_en_q   <= is_jmp;
            jump_addr   <= is_jmp ? jaddr_c : '0;
            f3_q        <= f3;
            off_q       <= off_c;
        end else if (state == MWAIT && mem_resp_valid
                     && !mem_req_wen) begin
            wb_data <= ld_res;
        end
    end

    assign jump_en = jump_en_q && wb_valid;

endmodule

// File: tb/tb_ysyx_23060332_exu_mc.sv
// tb_ysyx_23060332_exu_mc: directed and random checks of the execute unit.
// Expected values come from a behavioural RV model inside the bench.

module tb_ysyx_23060332_exu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] inst, op1, op2, op1_jump, op2_jump, rs2_data;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_ready, wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        jump_en;
    logic [31:0] jump_addr;

    ysyx_23060332_exu_mc u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .op1(op1), .op2(op2),
        .op1_jump(op1_jump), .op2_jump(op2_jump),
        .rs2_data(rs2_data), .rd(rd), .rd_wen(rd_wen),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .jump_en(jump_en), .jump_addr(jump_addr)
    );

    // 64-bit build
    logic        d_in_valid, d_in_ready;
    logic [31:0] d_inst;
    logic [63:0] d_op1, d_op2, d_rs2;
    logic        d_req_valid, d_req_ready, d_req_wen;
    logic [63:0] d_addr, d_wdata, d_rdata, d_wb_data, d_jaddr;
    logic [7:0]  d_wmask;
    logic        d_resp_valid, d_wb_valid, d_wb_ready, d_wb_wen;
    logic [4:0]  d_wb_rd;
    logic        d_jump_en;

    ysyx_23060332_exu_mc #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .inst(d_inst), .op1(d_op1), .op2(d_op2),
        .op1_jump(64'd0), .op2_jump(64'd0),
        .rs2_data(d_rs2), .rd(5'd7), .rd_wen(1'b1),
        .mem_req_valid(d_req_valid),
        .mem_req_ready(d_req_ready),
        .mem_req_wen(d_req_wen), .mem_addr(d_addr),
        .mem_wdata(d_wdata), .mem_wmask(d_wmask),
        .mem_resp_valid(d_resp_valid),
        .mem_rdata(d_rdata),
        .wb_valid(d_wb_valid), .wb_ready(d_wb_ready),
        .wb_rd(d_wb_rd), .wb_wen(d_wb_wen),
        .wb_data(d_wb_data),
        .jump_en(d_jump_en), .jump_addr(d_jaddr)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] last_data, last_jaddr;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        wen;
        logic        jen;
        logic [31:0] jaddr;
        bit          mem;
        bit          st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } exp_t;

    function automatic logic [31:0] mk(input logic [6:0] o,
                                       input logic [2:0] f,
                                       input logic b30);
        return 32'(o) | (32'(f) << 12) | (32'(b30) << 30);
    endfunction

    // Architectural meaning of one RV32 instruction.
    function automatic exp_t model(
        input logic [31:0] ins, a, b, j1, j2, rs2,
        input logic [4:0] r, input logic w,
        input logic [31:0] rdata);
        exp_t e;
        int unsigned n, off;
        bit sgn, ok;
        longint unsigned v, m;
        e = '{default: '0};
        ok = 1'b0;
        case (ins[6:0])
            7'h13, 7'h33: begin
                ok = 1'b1;
                case (ins[14:12])
                    0: e.data = (ins[6:0] == 7'h33 && ins[30])
                                ? a - b : a + b;
                    2: e.data = (int'(a) < int'(b)) ? 1 : 0;
                    3: e.data = (a < b) ? 1 : 0;
                    4: e.data = a ^ b;
                    6: e.data = a | b;
                    7: e.data = a & b;
                    default: ok = 1'b0;
                endcase
            end
            7'h37, 7'h17: begin ok = 1'b1; e.data = a + b; end
            7'h6f, 7'h67: begin
                ok = 1'b1;
                e.data = a + b;
                e.jen = 1'b1;
                e.jaddr = j1 + j2;
                if (ins[6:0] == 7'h67) e.jaddr[0] = 1'b0;
            end
            7'h03: begin
                n = 1 << ins[13:12];
                sgn = !ins[14];
                if (n <= 4 && !(ins[14] && n == 4)) begin
                    ok = 1'b1;
                    e.mem = 1'b1;
                    e.addr = a + b;
                    off = e.addr % 4;
                    v = 64'(rdata) >> (8 * off);
                    m = (64'd1 << (8 * n)) - 1;
                    v = v & m;
                    if (sgn && ((v >> (8 * n - 1)) & 1) == 1)
                        v = v | ~m;
                    e.data = v[31:0];
                end
            end
            7'h23: begin
                n = 1 << ins[13:12];
                if (!ins[14] && n <= 4) begin
                    e.mem = 1'b1;
                    e.st = 1'b1;
                    e.addr = a + b;
                    off = e.addr % 4;
                    e.mask = 4'(((1 << n) - 1) << off);
                    e.wdata = rs2 << (8 * off);
                end
            end
            default: ;
        endcase
        e.wen = ok && w && (r != 0);
        if (!ok) e.data = 0;
        return e;
    endfunction

    task automatic run(input string tag,
                       input logic [31:0] ins, a, b, j1, j2, rs2,
                       input logic [4:0] r, input logic w,
                       input int rq_d, rs_d, wb_d,
                       input logic [31:0] rdata);
        exp_t e;
        e = model(ins, a, b, j1, j2, rs2, r, w, rdata);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; inst = ins; op1 = a; op2 = b;
        op1_jump = j1; op2_jump = j2; rs2_data = rs2;
        rd = r; rd_wen = w;
        @(negedge clk);
        in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
        op1_jump = $urandom; op2_jump = $urandom;
        rs2_data = $urandom; rd = 5'($urandom);
        inst = $urandom;
        if (e.mem) begin
            for (int i = 0; i <= rq_d; i++) begin
                chk({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
                chk({tag, ".addr"}, 64'(mem_addr), 64'(e.addr));
                chk({tag, ".req_wen"}, 64'(mem_req_wen), 64'(e.st));
                if (e.st) begin
                    chk({tag, ".wmask"}, 64'(mem_wmask), 64'(e.mask));
                    chk({tag, ".wdata"}, 64'(mem_wdata), 64'(e.wdata));
                end
                if (i == rq_d) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            chk({tag, ".req_drop"}, 64'(mem_req_valid), 64'd0);
            for (int i = 0; i < rs_d; i++) begin
                @(negedge clk);
                chk({tag, ".early_wb"}, 64'(wb_valid), 64'd0);
            end
            mem_resp_valid = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_rdata = $urandom;
        end
        for (int i = 0; i <= wb_d; i++) begin
            chk({tag, ".wb_valid"}, 64'(wb_valid), 64'd1);
            chk({tag, ".wb_rd"}, 64'(wb_rd), 64'(r));
            chk({tag, ".wb_wen"}, 64'(wb_wen), 64'(e.wen));
            chk({tag, ".jump_en"}, 64'(jump_en), 64'(e.jen));
            if (!e.st)
                chk({tag, ".wb_data"}, 64'(wb_data), 64'(e.data));
            if (e.jen)
                chk({tag, ".jaddr"}, 64'(jump_addr), 64'(e.jaddr));
            chk({tag, ".busy"}, 64'(in_ready), 64'd0);
            if (i == wb_d) wb_ready = 1'b1;
            last_data = wb_data;
            last_jaddr = jump_addr;
            @(negedge clk);
        end
        wb_ready = 1'b0;
        chk({tag, ".wb_drop"}, 64'(wb_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [10:0] pick(input int i);
        case (i)
            0:  return {1'b0, 3'd0, 7'h13};
            1:  return {1'b0, 3'd2, 7'h13};
            2:  return {1'b0, 3'd3, 7'h13};
            3:  return {1'b0, 3'd4, 7'h13};
            4:  return {1'b0, 3'd6, 7'h13};
            5:  return {1'b0, 3'd7, 7'h13};
            6:  return {1'b0, 3'd0, 7'h33};
            7:  return {1'b1, 3'd0, 7'h33};
            8:  return {1'b0, 3'd2, 7'h33};
            9:  return {1'b0, 3'd3, 7'h33};
            10: return {1'b0, 3'd4, 7'h33};
            11: return {1'b0, 3'd6, 7'h33};
            12: return {1'b0, 3'd7, 7'h33};
            13: return {1'b0, 3'd0, 7'h37};
            14: return {1'b0, 3'd0, 7'h17};
            15: return {1'b0, 3'd0, 7'h6f};
            16: return {1'b0, 3'd0, 7'h67};
            17: return {1'b0, 3'd0, 7'h03};
            18: return {1'b0, 3'd1, 7'h03};
            19: return {1'b0, 3'd2, 7'h03};
            20: return {1'b0, 3'd4, 7'h03};
            21: return {1'b0, 3'd5, 7'h03};
            22: return {1'b0, 3'd0, 7'h23};
            23: return {1'b0, 3'd1, 7'h23};
            24: return {1'b0, 3'd2, 7'h23};
            25: return {1'b0, 3'd0, 7'h7f};
            26: return {1'b0, 3'd1, 7'h13};
            27: return {1'b0, 3'd3, 7'h03};
            default: return {1'b0, 3'd3, 7'h23};
        endcase
    endfunction

    initial begin
        logic [10:0] p;
        logic [31:0] ins;
        rst_n = 1'b0; in_valid = 1'b0; inst = '0;
        op1 = '0; op2 = '0; op1_jump = '0; op2_jump = '0;
        rs2_data = '0; rd = '0; rd_wen = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = '0; wb_ready = 1'b0;
        d_in_valid = 1'b0; d_inst = '0; d_op1 = '0;
        d_op2 = '0; d_rs2 = '0; d_req_ready = 1'b0;
        d_resp_valid = 1'b0; d_rdata = '0; d_wb_ready = 1'b0;
        last_data = '0; last_jaddr = '0;

        repeat (2) @(negedge clk);
        chk("rst.wb_valid", 64'(wb_valid), 64'd0);
        chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst.wb_data", 64'(wb_data), 64'd0);
        chk("rst.jump_en", 64'(jump_en), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        run("addi", mk(7'h13, 3'd0, 1'b0), 32'd5, 32'hFFFFFFFF,
            0, 0, 0, 5'd3, 1'b1, 0, 0, 0, 0);
        chk("addi.const", 64'(last_data), 64'd4);

        run("jalr", mk(7'h67, 3'd0, 1'b0), 32'h80000000, 32'd4,
            32'h80001001, 0, 0, 5'd1, 1'b1, 0, 0, 0, 0);
        chk("jalr.const_d", 64'(last_data), 64'h80000004);
        chk("jalr.const_j", 64'(last_jaddr), 64'h80001000);

        run("sb", mk(7'h23, 3'd0, 1'b0), 32'h80000000, 32'd3,
            0, 0, 32'h000000AB, 5'd0, 1'b0, 3, 1, 0, 0);

        run("lh", mk(7'h03, 3'd1, 1'b0), 32'd2, 32'd0,
            0, 0, 0, 5'd9, 1'b1, 0, 2, 0, 32'h80010000);
        chk("lh.const", 64'(last_data), 64'hFFFF8001);
        run("lhu", mk(7'h03, 3'd5, 1'b0), 32'd2, 32'd0,
            0, 0, 0, 5'd9, 1'b1, 1, 0, 0, 32'h80010000);
        chk("lhu.const", 64'(last_data), 64'h00008001);

        run("hold", mk(7'h33, 3'd0, 1'b1), 32'd10, 32'd3,
            0, 0, 0, 5'd4, 1'b1, 0, 0, 4, 0);
        run("rd0", mk(7'h13, 3'd0, 1'b0), 32'd1, 32'd1,
            0, 0, 0, 5'd0, 1'b1, 0, 0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            p = pick(int'($urandom_range(0, 28)));
            ins = mk(p[6:0], p[9:7], p[10]);
            ins = ins | ($urandom & 32'hBFFF8F80);
            if (p[6:0] != 7'h33) ins[30] = 1'($urandom);
            run($sformatf("rnd%0d", k), ins, $urandom, $urandom,
                $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)),
                1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), $urandom);
        end

        // Reset while waiting for load data.
        @(negedge clk);
        in_valid = 1'b1; inst = mk(7'h03, 3'd2, 1'b0);
        op1 = 32'h100; op2 = 32'd4; rd = 5'd5; rd_wen = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mrst.in_mwait", 64'(mem_req_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst.wb_valid", 64'(wb_valid), 64'd0);
        chk("mrst.req_valid", 64'(mem_req_valid), 64'd0);
        chk("mrst.addr", 64'(mem_addr), 64'd0);
        chk("mrst.wb_rd", 64'(wb_rd), 64'd0);
        chk("mrst.wb_wen", 64'(wb_wen), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("mrst.late_resp", 64'(wb_valid), 64'd0);
        @(negedge clk);
        chk("mrst.late_resp2", 64'(wb_valid), 64'd0);
        chk("mrst.in_ready", 64'(in_ready), 64'd1);

        // 64-bit build: SD at 0x8, then LWU with upper-word lane.
        d_in_valid = 1'b1; d_inst = mk(7'h23, 3'd3, 1'b0);
        d_op1 = 64'h8; d_op2 = 64'h0;
        d_rs2 = 64'h1122334455667788;
        @(negedge clk);
        d_in_valid = 1'b0;
        chk("sd.req_valid", 64'(d_req_valid), 64'd1);
        chk("sd.wmask", 64'(d_wmask), 64'hFF);
        chk("sd.addr", d_addr, 64'h8);
        chk("sd.wdata", d_wdata, 64'h1122334455667788);
        d_req_ready = 1'b1;
        @(negedge clk);
        d_req_ready = 1'b0; d_resp_valid = 1'b1;
        @(negedge clk);
        d_resp_valid = 1'b0;
        chk("sd.wb_valid", 64'(d_wb_valid), 64'd1);
        chk("sd.wb_wen", 64'(d_wb_wen), 64'd0);
        d_wb_ready = 1'b1;
        @(negedge clk);
        d_wb_ready = 1'b0;
        d_in_valid = 1'b1; d_inst = mk(7'h03, 3'd6, 1'b0);
        d_op1 = 64'h4; d_op2 = 64'h0;
        @(negedge clk);
        d_in_valid = 1'b0; d_req_ready = 1'b1;
        @(negedge clk);
        d_req_ready = 1'b0; d_resp_valid = 1'b1;
        d_rdata = 64'h80000001_00000000;
        @(negedge clk);
        d_resp_valid = 1'b0;
        chk("lwu.wb_data", d_wb_data, 64'h0000000080000001);
        chk("lwu.wb_wen", 64'(d_wb_wen), 64'd1);
        d_wb_ready = 1'b1;
        @(negedge clk);
        d_wb_ready = 1'b0;
        chk("lwu.in_ready", 64'(d_in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
